spi_dac_responder: RTL and testbench



---
 rtl/spi_dac_pkg.sv | 21 ++
 rtl/spi_dac_responder_sync.sv | 46 ++++
 rtl/spi_dac_responder.sv | 142 ++++++++++++++
 tb/tb_spi_dac_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dac_pkg.sv
// Shared types and helpers for the DAC-link SPI responder.
package spi_dac_pkg;

  localparam int unsigned FRAME_BITS_DEFAULT = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_IDLE} state_e;

  // Returns {exactly_one_low, index_of_low_line}; index is 0 unless exactly one line is low.
  function automatic logic [2:0] ncs_decode(input logic [3:0] ncs);
    logic [2:0] res;
    case (ncs)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = {1'b0, 2'd0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spi_dac_responder_sync.sv
// Synchronizes the SPI pins into clk and registers Sck edge events. Every output carries the
// same SYNC_STAGES+1 cycle delay so Mosi and nCs stay aligned with the Sck edge pulses.
// SYNC_STAGES must be at least 2.
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Sck,
  input  logic       Mosi,
  input  logic [3:0] nCs,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       mosi_s,
  output logic [3:0] ncs_s
);

  logic [SYNC_STAGES-1:0]      sck_sync_q;
  logic [SYNC_STAGES-1:0]      mosi_sync_q;
  logic [SYNC_STAGES-1:0][3:0] ncs_sync_q;
  logic                        sck_prev_q;

  // Synchronizer chains followed by the edge-detect register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '1;
      mosi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sck_prev_q  <= 1'b1;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      mosi_s      <= 1'b0;
      ncs_s       <= 4'hF;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], Sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], Mosi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCs};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      sck_rise    <= sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
      sck_fall    <= ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
      mosi_s      <= mosi_sync_q[SYNC_STAGES-1];
      ncs_s       <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_dac_responder.sv
// SPI mode-3 responder for the DAC board link: receives FRAME_BITS-bit frames on one of four
// chip selects and returns a readback word on Miso within the same frame.
module spi_dac_responder
  import spi_dac_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Sck,
  input  logic                  Mosi,
  input  logic [3:0]            nCs,
  input  logic [FRAME_BITS-1:0] TxData,
  output logic                  Miso,
  output logic                  MisoOE,
  output logic [FRAME_BITS-1:0] RxData,
  output logic [1:0]            RxChannel,
  output logic                  FrameValid,
  output logic                  FrameError,
  output logic                  Busy
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 2);

  logic            sck_rise, sck_fall, mosi_s;
  logic [3:0]      ncs_s;
  logic [2:0]      dec;
  logic            all_high;

  state_e                state_q;
  logic [FRAME_BITS-1:0] tx_shift_q;
  logic [FRAME_BITS-1:0] rx_shift_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [1:0]            chan_q;
  // warm_q fills with ones after reset; until its top bit is set ncs_s still shows reset
  // values rather than the pins, so those cycles must not count as an idle bus.
  logic [SYNC_STAGES:0]  warm_q;
  logic                  prev_idle_q;

  spi_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .Sck     (Sck),
    .Mosi    (Mosi),
    .nCs     (nCs),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .mosi_s  (mosi_s),
    .ncs_s   (ncs_s)
  );

  assign dec      = ncs_decode(ncs_s);
  assign all_high = &ncs_s;

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      chan_q      <= 2'd0;
      warm_q      <= '0;
      prev_idle_q <= 1'b0;
      Miso        <= 1'b1;
      MisoOE      <= 1'b0;
      RxData      <= '0;
      RxChannel   <= 2'd0;
      FrameValid  <= 1'b0;
      FrameError  <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      FrameValid  <= 1'b0;
      FrameError  <= 1'b0;
      warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      prev_idle_q <= warm_q[SYNC_STAGES] & all_high;
      unique case (state_q)
        IDLE: begin
          if (!all_high) begin
            Busy <= 1'b1;
            if (!prev_idle_q) begin
              // Bus was already active (e.g. reset released mid-frame): sit it out silently.
              state_q <= WAIT_IDLE;
            end else if (dec[2]) begin
              state_q    <= SHIFT;
              tx_shift_q <= TxData;
              rx_shift_q <= '0;
              chan_q     <= dec[1:0];
              bit_cnt_q  <= '0;
              MisoOE     <= 1'b1;
            end else begin
              state_q    <= WAIT_IDLE;
              FrameError <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (all_high) begin
            if (bit_cnt_q == CntW'(FRAME_BITS)) begin
              FrameValid <= 1'b1;
              RxData     <= rx_shift_q;
              RxChannel  <= chan_q;
            end else begin
              FrameError <= 1'b1;
            end
            state_q <= IDLE;
            Miso    <= 1'b1;
            MisoOE  <= 1'b0;
            Busy    <= 1'b0;
          end else if (ncs_s != ~(4'b0001 << chan_q)) begin
            FrameError <= 1'b1;
            state_q    <= WAIT_IDLE;
            Miso       <= 1'b1;
            MisoOE     <= 1'b0;
          end else begin
            if (sck_fall) begin
              Miso       <= tx_shift_q[FRAME_BITS-1];
              tx_shift_q <= {tx_shift_q[FRAME_BITS-2:0], 1'b0};
            end
            if (sck_rise) begin
              rx_shift_q <= {rx_shift_q[FRAME_BITS-2:0], mosi_s};
              if (bit_cnt_q != CntW'(FRAME_BITS + 1)) begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (all_high) begin
            state_q <= IDLE;
            Busy    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dac_responder.sv
// Directed bench for spi_dac_responder: drives mode-3 SPI frames at clk/10 and checks the
// received word, channel, readback stream and frame pulses against hand-computed values.
module tb_spi_dac_responder;

  localparam int Half = 5;  // clk cycles per Sck phase

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Sck = 1'b1;
  logic        Mosi = 1'b0;
  logic [3:0]  nCs = 4'hF;
  logic [31:0] TxData = '0;
  logic        Miso, MisoOE, FrameValid, FrameError, Busy;
  logic [31:0] RxData;
  logic [1:0]  RxChannel;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int miso_low_cnt = 0;
  int oe_cnt = 0;

  spi_dac_responder #(
    .FRAME_BITS (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Sck       (Sck),
    .Mosi      (Mosi),
    .nCs       (nCs),
    .TxData    (TxData),
    .Miso      (Miso),
    .MisoOE    (MisoOE),
    .RxData    (RxData),
    .RxChannel (RxChannel),
    .FrameValid(FrameValid),
    .FrameError(FrameError),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  // Pulse counters: a one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (FrameValid === 1'b1) valid_cnt++;
    if (FrameError === 1'b1) error_cnt++;
    if (Miso !== 1'b1) miso_low_cnt++;
    if (MisoOE === 1'b1) oe_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cs_begin(input logic [3:0] pattern);
    nCs = pattern;
    repeat (Half) @(negedge clk);
  endtask

  task automatic cs_end(input int post);
    repeat (Half) @(negedge clk);
    nCs = 4'hF;
    repeat (post) @(negedge clk);
  endtask

  // Shifts nbits frame bits starting at frame bit 'start'; Miso is captured just before each
  // rising edge, where the master samples it.
  task automatic shift_bits(input int nbits, input logic [31:0] word, input int start,
                            output logic [31:0] miso_word);
    miso_word = '0;
    for (int i = 0; i < nbits; i++) begin
      Sck  = 1'b0;
      Mosi = (start + i < 32) ? word[31-(start+i)] : 1'b0;
      repeat (Half) @(negedge clk);
      miso_word = {miso_word[30:0], Miso};
      Sck = 1'b1;
      repeat (Half) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (Miso !== 1'b1) begin errors++; $display("FAIL reset_miso got %b want 1", Miso); end
    checks++; if (MisoOE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", MisoOE); end
    checks++; if (RxData !== 32'h0) begin errors++; $display("FAIL reset_rxdata got %h want 0", RxData); end
    checks++; if (RxChannel !== 2'd0) begin errors++; $display("FAIL reset_chan got %0d want 0", RxChannel); end
    checks++; if (FrameValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", FrameValid); end
    checks++; if (FrameError !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", FrameError); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] m;
    int v0, e0;
    v0 = valid_cnt; e0 = error_cnt;
    TxData = 32'h1234_5678;
    cs_begin(4'b1110);
    shift_bits(32, 32'hA5C3_0F12, 0, m);
    cs_end(10);
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL basic_valid got %0d want 1", valid_cnt - v0); end
    checks++; if (error_cnt - e0 != 0) begin errors++; $display("FAIL basic_error got %0d want 0", error_cnt - e0); end
    checks++; if (RxData !== 32'hA5C3_0F12) begin errors++; $display("FAIL basic_rxdata got %h want a5c30f12", RxData); end
    checks++; if (RxChannel !== 2'd0) begin errors++; $display("FAIL basic_chan got %0d want 0", RxChannel); end
    checks++; if (m !== 32'h1234_5678) begin errors++; $display("FAIL basic_miso got %h want 12345678", m); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", Busy); end
  endtask

  task automatic test_channel_and_short();
    logic [31:0] m;
    int v0, e0;
    cs_begin(4'b0111);
    shift_bits(32, 32'hA5C3_0F12, 0, m);
    cs_end(10);
    checks++; if (RxChannel !== 2'd3) begin errors++; $display("FAIL ch3_chan got %0d want 3", RxChannel); end
    checks++; if (RxData !== 32'hA5C3_0F12) begin errors++; $display("FAIL ch3_rxdata got %h want a5c30f12", RxData); end
    v0 = valid_cnt; e0 = error_cnt;
    cs_begin(4'b1101);
    shift_bits(31, 32'h1357_9BDF, 0, m);
    cs_end(10);
    checks++; if (error_cnt - e0 != 1) begin errors++; $display("FAIL short_error got %0d want 1", error_cnt - e0); end
    checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL short_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (RxData !== 32'hA5C3_0F12) begin errors++; $display("FAIL short_rxdata got %h want a5c30f12", RxData); end
    checks++; if (RxChannel !== 2'd3) begin errors++; $display("FAIL short_chan got %0d want 3", RxChannel); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m;
    int v0, e0, v1, e1;
    v0 = valid_cnt; e0 = error_cnt;
    cs_begin(4'b1011);
    shift_bits(33, 32'hFFFF_FFFF, 0, m);
    cs_end(1);
    // Next frame starts one clk after nCs rose.
    cs_begin(4'b1011);
    v1 = valid_cnt; e1 = error_cnt;
    shift_bits(32, 32'hDEAD_BEEF, 0, m);
    cs_end(10);
    checks++; if (e1 - e0 != 1) begin errors++; $display("FAIL long_error got %0d want 1", e1 - e0); end
    checks++; if (v1 - v0 != 0) begin errors++; $display("FAIL long_valid got %0d want 0", v1 - v0); end
    checks++; if (valid_cnt - v1 != 1) begin errors++; $display("FAIL b2b_valid got %0d want 1", valid_cnt - v1); end
    checks++; if (error_cnt - e1 != 0) begin errors++; $display("FAIL b2b_error got %0d want 0", error_cnt - e1); end
    checks++; if (RxData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rxdata got %h want deadbeef", RxData); end
    checks++; if (RxChannel !== 2'd2) begin errors++; $display("FAIL b2b_chan got %0d want 2", RxChannel); end
  endtask

  task automatic test_multi_cs();
    int v0, e0, ml0, oe0;
    v0 = valid_cnt; e0 = error_cnt; ml0 = miso_low_cnt; oe0 = oe_cnt;
    nCs = 4'b1010;
    repeat (10) @(negedge clk);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL multi_busy_start got %b want 1", Busy); end
    for (int i = 0; i < 32; i++) begin
      Sck = 1'b0; Mosi = i[0];
      repeat (Half) @(negedge clk);
      Sck = 1'b1;
      repeat (Half) @(negedge clk);
    end
    nCs = 4'b1110;
    repeat (10) @(negedge clk);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL multi_busy_one_low got %b want 1", Busy); end
    nCs = 4'hF;
    repeat (10) @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL multi_busy_end got %b want 0", Busy); end
    checks++; if (error_cnt - e0 != 1) begin errors++; $display("FAIL multi_error got %0d want 1", error_cnt - e0); end
    checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL multi_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (miso_low_cnt - ml0 != 0) begin errors++; $display("FAIL multi_miso_low got %0d cycles want 0", miso_low_cnt - ml0); end
    checks++; if (oe_cnt - oe0 != 0) begin errors++; $display("FAIL multi_oe got %0d cycles want 0", oe_cnt - oe0); end
    checks++; if (RxData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL multi_rxdata got %h want deadbeef", RxData); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] m;
    int v0, e0;
    TxData = 32'h8000_0000;
    cs_begin(4'b1110);
    shift_bits(10, 32'hFFFF_FFFF, 0, m);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (RxData !== 32'h0) begin errors++; $display("FAIL midrst_rxdata got %h want 0", RxData); end
    checks++; if (MisoOE !== 1'b0 || Miso !== 1'b1) begin errors++; $display("FAIL midrst_miso got oe=%b miso=%b want 0/1", MisoOE, Miso); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", Busy); end
    rst = 1'b0;
    v0 = valid_cnt; e0 = error_cnt;
    shift_bits(22, 32'hFFFF_FFFF, 10, m);
    checks++; if (Busy !== 1'b1 || MisoOE !== 1'b0) begin errors++; $display("FAIL midrst_wait got busy=%b oe=%b want 1/0", Busy, MisoOE); end
    cs_end(10);
    checks++; if (valid_cnt - v0 != 0 || error_cnt - e0 != 0) begin
      errors++; $display("FAIL midrst_pulses got valid=%0d error=%0d want 0/0", valid_cnt - v0, error_cnt - e0);
    end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b want 0", Busy); end
    v0 = valid_cnt;
    cs_begin(4'b1110);
    shift_bits(32, 32'h0000_0001, 0, m);
    cs_end(10);
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL after_rst_valid got %0d want 1", valid_cnt - v0); end
    checks++; if (RxData !== 32'h0000_0001) begin errors++; $display("FAIL after_rst_rxdata got %h want 00000001", RxData); end
  endtask

  task automatic test_tx_change();
    logic [31:0] m1, m2, m;
    TxData = 32'hFFFF_0000;
    cs_begin(4'b1011);
    shift_bits(5, 32'h5A5A_5A5A, 0, m1);
    TxData = 32'h0000_FFFF;
    shift_bits(27, 32'h5A5A_5A5A, 5, m2);
    cs_end(10);
    m = (m1 << 27) | m2;
    checks++; if (m !== 32'hFFFF_0000) begin errors++; $display("FAIL txchg_miso got %h want ffff0000", m); end
    checks++; if (RxData !== 32'h5A5A_5A5A) begin errors++; $display("FAIL txchg_rxdata got %h want 5a5a5a5a", RxData); end
    checks++; if (RxChannel !== 2'd2) begin errors++; $display("FAIL txchg_chan got %0d want 2", RxChannel); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_channel_and_short();
    test_back_to_back();
    test_multi_cs();
    test_reset_midframe();
    test_tx_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
